pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Sequences the five-stage MIPS pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) by generating their write-enables and bubble/flush strobes.
- Handles three hazard sources:
  - load-use data hazards detected in ID;
  - taken branches resolved in MEM, which flush three younger instructions;
  - multi-cycle data-memory waits, which freeze the whole pipeline.
- Also keeps stall and flush statistics and a sticky memory-timeout flag.

Parameters:
- REG_W, 5: register-specifier width.
- CNT_W, 16: width of the saturating statistics counters.
- MAX_WAIT, 15: memory-wait cycles tolerated before mem_timeout is set.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  REG_W  rs of instruction in ID
- id_rt  in  REG_W  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_memread  in  1  MemRead of instruction in EX (ID/EX output)
- ex_rt  in  REG_W  load destination rt of instruction in EX
- mem_branch_taken  in  1  Branch & zero of instruction in MEM
- mem_access  in  1  MEM-stage instruction has MemRead or MemWrite set
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID clears to NOP
- idex_write  out  1  ID/EX write enable
- idex_bubble  out  1  ID/EX control fields load 0
- exmem_write  out  1  EX/MEM write enable
- exmem_bubble  out  1  EX/MEM control fields load 0
- memwb_bubble  out  1  MEM/WB control fields load 0
- mem_timeout  out  1  sticky: memory wait exceeded MAX_WAIT
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- flush_events  out  CNT_W  saturating count of branch flushes

Behaviour:
- Reset (rst high, asynchronous):
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
  - While rst is high, the control outputs are forced to: all *_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, memwb_bubble=1.
  - First cycle after release: normal evaluation.
- Derived signals:
  - mem_busy = mem_access & ~mem_ready.
  - lu_hazard = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Control outputs are Mealy (combinational from state and inputs, same cycle). Priority is mem_busy > mem_branch_taken > lu_hazard > normal.
- MEM stall (mem_busy=1):
  - All *_write=0 and memwb_bubble=1.
  - Other bubbles/flush stay 0 (contents are held).
  - State becomes or stays MEM_WAIT.
- Branch flush (mem_branch_taken=1, not mem_busy):
  - pc_write=1, ifid_write=1, idex_write=1, exmem_write=1.
  - ifid_flush=1, idex_bubble=1, exmem_bubble=1.
  - Exactly one cycle; flush_events+1.
  - A concurrent lu_hazard is ignored, because the dependent instruction is flushed.
- Load-use stall (lu_hazard only):
  - pc_write=0, ifid_write=0, idex_bubble=1; idex_write=1, exmem_write=1.
  - Lasts one cycle. It clears by itself next cycle because the load has advanced to EX/MEM.
- Normal: all *_write=1, all bubbles/flush=0.
- State machine, states {RUN, MEM_WAIT}:
  - RUN→MEM_WAIT when mem_busy.
  - MEM_WAIT→RUN on the first cycle with mem_busy=0. That cycle is evaluated normally, so a branch or load-use hazard is honoured in it.
- wait_cnt:
  - Increments each MEM_WAIT cycle with mem_busy=1 and saturates at MAX_WAIT.
  - Reaching MAX_WAIT while still busy sets mem_timeout. mem_timeout clears only by rst.
  - wait_cnt returns to 0 on leaving MEM_WAIT.
- stall_cycles:
  - +1 on every cycle with pc_write=0 (MEM stall or load-use).
  - Saturates at all-ones and does not wrap.
- flush_events: same saturation rule.
- Register $zero is never a hazard source (ex_rt=0 gives no stall).

Decomposition:
- Shared package mips_pipe_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - the REG_ZERO constant;
  - a pipe_ctrl_t struct bundling the eight enable/bubble outputs, reused by the pipeline-register blocks.
- One sub-module, pipe_lu_detect: combinational load-use comparator (id_rs, id_rt, id_uses_rt, ex_memread, ex_rt → lu_hazard).
- The FSM, counters and priority mux stay in the top module.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cycles=1; next cycle with ex_memread=0 → all writes 1.
- Zero register / unused rt: ex_rt=0, id_rs=0 → no stall. ex_rt=9, id_rt=9, id_uses_rt=0 → no stall.
- Branch taken: mem_branch_taken=1 for one cycle with lu_hazard also true → ifid_flush=idex_bubble=exmem_bubble=1, pc_write=1; flush_events=1; stall_cycles unchanged.
- Memory wait: mem_access=1, mem_ready=0 for 4 cycles, then ready → 4 cycles with all writes 0 and memwb_bubble=1; stall_cycles=4; state back to RUN; mem_timeout=0.
- Timeout: mem_ready=0 for 20 cycles → mem_timeout=1 from the cycle wait_cnt reaches 15; it stays 1 after ready returns; it clears only when rst is asserted mid-wait. After that rst pulse, outputs show reset values and counters=0.
- Saturation: force 2^CNT_W+3 stall cycles → stall_cycles holds at 0xFFFF.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control slice.
package mips_pipe_pkg;

  // Hazard-controller sequencing states.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_t;

  // Register $zero is hard-wired and can never carry a load result.
  localparam int REG_ZERO = 0;

  // Enables and strobes for the five pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_bubble;
    logic memwb_bubble;
  } pipe_ctrl_t;

  // Advance every register with no bubbles.
  localparam pipe_ctrl_t CTRL_NORMAL    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                            idex_write: 1'b1, idex_bubble: 1'b0, exmem_write: 1'b1,
                                            exmem_bubble: 1'b0, memwb_bubble: 1'b0};
  // Freeze everything and drain a bubble into WB while memory is busy.
  localparam pipe_ctrl_t CTRL_MEM_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                            idex_write: 1'b0, idex_bubble: 1'b0, exmem_write: 1'b0,
                                            exmem_bubble: 1'b0, memwb_bubble: 1'b1};
  // Kill the three instructions younger than the taken branch.
  localparam pipe_ctrl_t CTRL_FLUSH     = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                            idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1,
                                            exmem_bubble: 1'b1, memwb_bubble: 1'b0};
  // Hold PC and IF/ID, insert a bubble behind the load.
  localparam pipe_ctrl_t CTRL_LU_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                            idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1,
                                            exmem_bubble: 1'b0, memwb_bubble: 1'b0};
  // Held while reset is asserted: nothing written, every stage cleared.
  localparam pipe_ctrl_t CTRL_RESET     = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                            idex_write: 1'b0, idex_bubble: 1'b1, exmem_write: 1'b0,
                                            exmem_bubble: 1'b1, memwb_bubble: 1'b1};

endpackage

// File: rtl/pipe_lu_detect.sv
// Load-use hazard comparator: a load in EX feeding a source of the ID instruction.
module pipe_lu_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu_hazard
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  // A load into $zero produces nothing that can be consumed.
  assign dest_live = ex_memread && (ex_rt != REG_W'(REG_ZERO));
  assign rs_match  = (ex_rt == id_rs);
  assign rt_match  = id_uses_rt && (ex_rt == id_rt);
  assign lu_hazard = dest_live && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: memory-wait freeze, branch flush, load-use stall,
// plus stall/flush statistics and a sticky memory-timeout flag.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  pipe_state_t       state, state_next;
  pipe_ctrl_t        ctrl;
  logic              lu_hazard;
  logic              mem_busy;
  logic              flush_now;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;

  pipe_lu_detect #(.REG_W(REG_W)) u_lu_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu_hazard  (lu_hazard)
  );

  assign mem_busy  = mem_access && !mem_ready;
  assign flush_now = mem_branch_taken && !mem_busy;
  assign wait_inc  = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state and prioritised Mealy control: reset > mem wait > branch > load-use > normal.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    ctrl       = CTRL_NORMAL;
    unique case (state)
      RUN:      if (mem_busy)  state_next = MEM_WAIT;
      MEM_WAIT: if (!mem_busy) state_next = RUN;
      default:  state_next = RUN;
    endcase
    if (rst)                   ctrl = CTRL_RESET;
    else if (mem_busy)         ctrl = CTRL_MEM_STALL;
    else if (mem_branch_taken) ctrl = CTRL_FLUSH;
    else if (lu_hazard)        ctrl = CTRL_LU_STALL;
  end

  // Memory-wait length tracking and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == MEM_WAIT && mem_busy) begin
      wait_cnt <= wait_inc;
      if (wait_inc == WAIT_MAX) mem_timeout <= 1'b1;
    end else if (!mem_busy) begin
      wait_cnt <= '0;
    end
  end

  // Saturating stall and flush statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (flush_now && flush_events != '1)      flush_events <= flush_events + 1'b1;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_write   = ctrl.idex_write;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_write  = ctrl.exmem_write;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed hazard sequences and
// randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W    = 5;
  localparam int CNT_W    = 16;
  localparam int MAX_WAIT = 15;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  // Control vector order: pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, exmem_bub, memwb_bub.
  localparam logic [7:0] E_NORM  = 8'b1101_0100;
  localparam logic [7:0] E_MEM   = 8'b0000_0001;
  localparam logic [7:0] E_FLUSH = 8'b1111_1110;
  localparam logic [7:0] E_LU    = 8'b0001_1100;
  localparam logic [7:0] E_RST   = 8'b0010_1011;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic             mem_branch_taken = 1'b0, mem_access = 1'b0, mem_ready = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic             exmem_write, exmem_bubble, memwb_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [7:0]       ctrl_obs;

  typedef struct {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rt;
    logic             memread;
    logic [REG_W-1:0] ex_rt;
    logic             br;
    logic             acc;
    logic             rdy;
    logic [7:0]       exp;
  } vec_t;

  vec_t tbl[11];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: counters as plain integers, memory wait as a streak length.
  int m_stall, m_flush, m_streak;
  bit m_timeout;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .ex_memread       (ex_memread),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .mem_access       (mem_access),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_write       (idex_write),
    .idex_bubble      (idex_bubble),
    .exmem_write      (exmem_write),
    .exmem_bubble     (exmem_bubble),
    .memwb_bubble     (memwb_bubble),
    .mem_timeout      (mem_timeout),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {pc_write, ifid_write, ifid_flush, idex_write,
                     idex_bubble, exmem_write, exmem_bubble, memwb_bubble};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    id_rs            = v.rs;
    id_rt            = v.rt;
    id_uses_rt       = v.uses_rt;
    ex_memread       = v.memread;
    ex_rt            = v.ex_rt;
    mem_branch_taken = v.br;
    mem_access       = v.acc;
    mem_ready        = v.rdy;
  endtask

  function automatic vec_t mk(input int rs, input int rt, input bit uses, input bit mr,
                              input int ert, input bit br, input bit acc, input bit rdy,
                              input logic [7:0] exp);
    vec_t v;
    v.rs = REG_W'(rs); v.rt = REG_W'(rt); v.uses_rt = uses; v.memread = mr;
    v.ex_rt = REG_W'(ert); v.br = br; v.acc = acc; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  // Expected control straight from the hazard rules on the current inputs.
  function automatic logic [7:0] model_ctrl();
    bit busy, lu;
    busy = mem_access && !mem_ready;
    lu   = ex_memread && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (busy)             return E_MEM;
    if (mem_branch_taken) return E_FLUSH;
    if (lu)               return E_LU;
    return E_NORM;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_streak = 0; m_timeout = 0;
  endtask

  // Advance the model by one clock with the current inputs.
  task automatic model_clock(input logic [7:0] c);
    bit busy;
    busy = mem_access && !mem_ready;
    if (!c[7] && m_stall < CNT_MAX) m_stall++;
    if (mem_branch_taken && !busy && m_flush < CNT_MAX) m_flush++;
    if (busy) begin
      m_streak++;
      // First busy cycle enters the wait; each later one adds to the wait count.
      if (m_streak - 1 >= MAX_WAIT) m_timeout = 1;
    end else begin
      m_streak = 0;
    end
  endtask

  // Starts and ends at posedge+1. Checks control before the edge, counters after.
  task automatic step(input string tag, input bit chk);
    logic [7:0] c;
    #2;
    c = model_ctrl();
    if (chk) check({tag, ".ctrl"}, 32'(ctrl_obs), 32'(c));
    model_clock(c);
    @(posedge clk); #1;
    if (chk) begin
      check({tag, ".stall"}, 32'(stall_cycles), 32'(m_stall));
      check({tag, ".flush"}, 32'(flush_events), 32'(m_flush));
      check({tag, ".timeout"}, 32'(mem_timeout), 32'(m_timeout));
    end
  endtask

  // Asynchronous reset pulse placed between clock edges; inputs keep driving.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, ".rst_ctrl"}, 32'(ctrl_obs), 32'(E_RST));
    check({tag, ".rst_stall"}, 32'(stall_cycles), 0);
    check({tag, ".rst_flush"}, 32'(flush_events), 0);
    check({tag, ".rst_timeout"}, 32'(mem_timeout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    vec_t idle, lu_v, busy_v, rdy_v;
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
    lu_v   = mk(8, 0, 0, 1, 8, 0, 0, 0, E_LU);
    busy_v = mk(0, 0, 0, 0, 0, 0, 1, 0, E_MEM);
    rdy_v  = mk(0, 0, 0, 0, 0, 0, 1, 1, E_NORM);

    tbl[0]  = idle;
    tbl[1]  = lu_v;
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, E_NORM);   // $zero never stalls
    tbl[3]  = mk(3, 9, 0, 1, 9, 0, 0, 0, E_NORM);   // rt match but rt unused
    tbl[4]  = mk(3, 9, 1, 1, 9, 0, 0, 0, E_LU);     // rt match and used
    tbl[5]  = mk(8, 0, 0, 0, 8, 0, 0, 0, E_NORM);   // not a load
    tbl[6]  = mk(8, 0, 0, 1, 8, 1, 0, 0, E_FLUSH);  // branch wins over load-use
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, E_MEM);    // memory wait wins over branch
    tbl[8]  = mk(8, 0, 0, 1, 8, 0, 1, 1, E_LU);     // exit cycle honours load-use
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
    tbl[10] = mk(0, 31, 1, 1, 31, 0, 0, 0, E_LU);   // highest register

    // Reset state while rst is held from time zero.
    #2;
    check("init.ctrl", 32'(ctrl_obs), 32'(E_RST));
    check("init.stall", 32'(stall_cycles), 0);
    check("init.flush", 32'(flush_events), 0);
    check("init.timeout", 32'(mem_timeout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Vector table: fixed expectations per row.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i]);
      #2;
      check($sformatf("tbl%0d.ctrl", i), 32'(ctrl_obs), 32'(tbl[i].exp));
      model_clock(tbl[i].exp);
      @(posedge clk); #1;
      check($sformatf("tbl%0d.stall", i), 32'(stall_cycles), 32'(m_stall));
    end

    // Load-use: one stall cycle, then the load has moved on.
    pulse_reset("lu");
    set_in(lu_v); step("lu.hit", 1);
    check("lu.stall_is_1", 32'(stall_cycles), 1);
    set_in(idle); step("lu.after", 1);
    check("lu.after_pc_write", 32'(pc_write), 1);

    // Branch flush with a concurrent load-use.
    pulse_reset("br");
    set_in(mk(8, 0, 0, 1, 8, 1, 0, 0, E_FLUSH)); step("br.hit", 1);
    check("br.flush_is_1", 32'(flush_events), 1);
    check("br.stall_is_0", 32'(stall_cycles), 0);

    // Four-cycle memory wait, then ready.
    pulse_reset("mw");
    set_in(busy_v);
    for (int i = 0; i < 4; i++) step($sformatf("mw.busy%0d", i), 1);
    set_in(rdy_v); step("mw.ready", 1);
    check("mw.stall_is_4", 32'(stall_cycles), 4);
    check("mw.no_timeout", 32'(mem_timeout), 0);

    // Timeout: boundary at the 16th busy cycle, sticky, cleared only by reset.
    pulse_reset("to");
    set_in(busy_v);
    for (int i = 0; i < 15; i++) step($sformatf("to.busy%0d", i), 1);
    check("to.not_yet", 32'(mem_timeout), 0);
    step("to.busy15", 1);
    check("to.set", 32'(mem_timeout), 1);
    for (int i = 16; i < 20; i++) step($sformatf("to.busy%0d", i), 1);
    set_in(rdy_v); step("to.ready", 1);
    set_in(idle);  step("to.idle", 1);
    check("to.sticky", 32'(mem_timeout), 1);
    set_in(busy_v); step("to.rewait0", 1); step("to.rewait1", 1);
    pulse_reset("to.midwait");
    set_in(idle); step("to.post_rst", 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 5) == 0), 1'($urandom),
             ($urandom_range(0, 2) != 0), E_NORM);
      set_in(v);
      step($sformatf("rnd%0d", i), 1);
    end

    // Saturation: hold a load-use hazard for 2^CNT_W + 3 cycles.
    pulse_reset("sat");
    set_in(lu_v);
    for (int i = 0; i < CNT_MAX + 4; i++) step("sat", 0);
    check("sat.stall", 32'(stall_cycles), 32'(16'hFFFF));
    check("sat.model", 32'(stall_cycles), 32'(m_stall));
    set_in(lu_v); step("sat.hold", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
